// File: rtl/dlx_dmem_ctrl.sv
// dlx_dmem_ctrl: DLX data-memory controller with posted store buffer and req/ack word-memory port
module dlx_dmem_ctrl #(
  parameter int SB_DEPTH = 4,
  parameter int SB_PTR_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_sext,
  input  logic [31:0] mem_addr,
  input  logic [31:0] memdata_out,
  output logic [31:0] memdata_in,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        ext_req,
  output logic        ext_we,
  output logic [29:0] ext_addr,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_be,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata
);
  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RD_DONE} state_t;
  state_t state, state_nx;
  logic [SB_PTR_W:0]   cnt;
  logic [SB_PTR_W-1:0] head, tail;
  logic [29:0] sb_addr [SB_DEPTH];
  logic [31:0] sb_data [SB_DEPTH];
  logic [3:0]  sb_be   [SB_DEPTH];
  logic [1:0]  lane;
  logic        act, bad, ld, st, full, hit, enq, pop, rd_go, wr_go, rd_ack;
  logic [31:0] st_data, ld_val;
  logic [3:0]  st_be;
  logic [15:0] half;
  logic [7:0]  byt;
  assign lane = mem_addr[1:0];
  always_comb begin
    act = mem_en && state != RD_DONE;
    bad = mem_size == 2'b11 || (mem_size == 2'b01 && lane[0]) || (mem_size == 2'b10 && lane != 2'b00);
    mem_misalign = act && bad;
    ld = act && !bad && !mem_we;
    st = act && !bad && mem_we;
    full = cnt == (SB_PTR_W+1)'(SB_DEPTH);
    enq = st && !full;
    mem_stall = ld || (st && full);
    hit = 1'b0;
    // an entry is live when its distance from head is below the registered count
    for (int i = 0; i < SB_DEPTH; i++)
      if ({1'b0, SB_PTR_W'(i) - head} < cnt && sb_addr[i] == mem_addr[31:2]) hit = 1'b1;
    rd_go = state == IDLE && ld && !hit;
    wr_go = state == IDLE && !rd_go && cnt != '0;
    pop = state == WR_WAIT && ext_ack;
    rd_ack = state == RD_WAIT && ext_ack;
    state_nx = rd_go ? RD_WAIT : wr_go ? WR_WAIT : (pop || state == RD_DONE) ? IDLE :
               rd_ack ? RD_DONE : state;
    st_data = mem_size == 2'b00 ? {4{memdata_out[7:0]}} :
              mem_size == 2'b01 ? {2{memdata_out[15:0]}} : memdata_out;
    st_be = mem_size == 2'b00 ? 4'b1000 >> lane : mem_size == 2'b01 ? (lane[1] ? 4'b0011 : 4'b1100) : 4'hF;
    byt = 8'(ext_rdata >> {~lane, 3'b000});
    half = lane[1] ? ext_rdata[15:0] : ext_rdata[31:16];
    ld_val = mem_size == 2'b00 ? {{24{mem_sext && byt[7]}}, byt} :
             mem_size == 2'b01 ? {{16{mem_sext && half[15]}}, half} : ext_rdata;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      head <= '0;
      tail <= '0;
      memdata_in <= '0;
      ext_req <= 1'b0;
      ext_we <= 1'b0;
      ext_addr <= '0;
      ext_wdata <= '0;
      ext_be <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt + (SB_PTR_W+1)'(enq) - (SB_PTR_W+1)'(pop);
      if (enq) tail <= tail + SB_PTR_W'(1);
      if (pop) head <= head + SB_PTR_W'(1);
      if (rd_go) begin
        ext_req <= 1'b1;
        ext_we <= 1'b0;
        ext_addr <= mem_addr[31:2];
        ext_be <= 4'hF;
      end else if (wr_go) begin
        ext_req <= 1'b1;
        ext_we <= 1'b1;
        ext_addr <= sb_addr[head];
        ext_wdata <= sb_data[head];
        ext_be <= sb_be[head];
      end else if (pop || rd_ack) begin
        ext_req <= 1'b0;
      end
      if (rd_ack) memdata_in <= ld_val;
    end
  end
  always_ff @(posedge clock) begin
    if (enq) begin
      sb_addr[tail] <= mem_addr[31:2];
      sb_data[tail] <= st_data;
      sb_be[tail] <= st_be;
    end
  end
endmodule

// File: tb/tb_dlx_dmem_ctrl.sv
// tb_dlx_dmem_ctrl: scoreboard bench for dlx_dmem_ctrl against a word-memory responder
module tb_dlx_dmem_ctrl;
  logic        clk = 0, reset = 1;
  logic        mem_en = 0, mem_we = 0, mem_sext = 0;
  logic [1:0]  mem_size = 0;
  logic [31:0] mem_addr = 0, memdata_out = 0, memdata_in;
  logic        mem_stall, mem_misalign, ext_req, ext_we, ext_ack;
  logic [29:0] ext_addr;
  logic [31:0] ext_wdata, ext_rdata;
  logic [3:0]  ext_be;
  int total = 0, bad = 0;
  logic        ack_en = 1;
  int          lat = 0;
  logic [31:0] mem [logic [29:0]];
  logic [65:0] wq [$];
  logic [31:0] lq [$];
  logic [30:0] txlog [$];

  dlx_dmem_ctrl dut (.clock(clk), .reset(reset), .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
    .mem_sext(mem_sext), .mem_addr(mem_addr), .memdata_out(memdata_out), .memdata_in(memdata_in),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign), .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_be(ext_be), .ext_ack(ext_ack), .ext_rdata(ext_rdata));

  always #5 clk = ~clk;

  // memory responder: acks after lat idle req cycles, applies writes and checks them against the store scoreboard
  initial begin
    int w;
    logic [65:0] e;
    logic [31:0] word;
    w = 0;
    ext_ack = 0;
    ext_rdata = 0;
    forever begin
      @(negedge clk);
      if (ext_ack || reset) begin
        ext_ack = 0;
        w = 0;
      end else if (ext_req && ack_en) begin
        if (w < lat) w++;
        else begin
          w = 0;
          ext_ack = 1;
          txlog.push_back({ext_we, ext_addr});
          word = mem.exists(ext_addr) ? mem[ext_addr] : 32'h0;
          if (ext_we) begin
            total++;
            e = wq.size() != 0 ? wq.pop_front() : 66'h0;
            if ({ext_addr, ext_wdata, ext_be} !== e) begin
              bad++;
              $display("FAIL ext_write got addr=%h data=%h be=%b want addr=%h data=%h be=%b",
                       ext_addr, ext_wdata, ext_be, e[65:36], e[35:4], e[3:0]);
            end
            for (int b = 0; b < 4; b++) if (ext_be[b]) word[8*b +: 8] = ext_wdata[8*b +: 8];
            mem[ext_addr] = word;
          end else ext_rdata = word;
        end
      end
    end
  end

  task automatic access(input logic we, input logic [1:0] sz, input logic sx, input logic [31:0] a, d,
                        input logic [65:0] wexp, input logic [31:0] rexp, input int exp_stalls, input string nm);
    int stalls;
    logic [31:0] e;
    if (we) wq.push_back(wexp);
    else lq.push_back(rexp);
    mem_en = 1; mem_we = we; mem_size = sz; mem_sext = sx; mem_addr = a; memdata_out = d;
    stalls = 0;
    @(negedge clk);
    while (mem_stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    total++;
    if (stalls !== exp_stalls) begin
      bad++;
      $display("FAIL %s stall cycles got %0d want %0d", nm, stalls, exp_stalls);
    end
    if (!we) begin
      e = lq.pop_front();
      total++;
      if (memdata_in !== e) begin
        bad++;
        $display("FAIL %s load data got %h want %h", nm, memdata_in, e);
      end
    end
    @(posedge clk);
    #1 mem_en = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({memdata_in, mem_stall, mem_misalign, ext_req, ext_we, ext_addr, ext_wdata, ext_be} !== 101'h0) begin
      bad++;
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h be=%b rd=%h want all zero",
               ext_req, ext_we, ext_addr, ext_wdata, ext_be, memdata_in);
    end
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_loads;
    mem[30'h400] = 32'h8081_7F01;
    ack_en = 1; lat = 0;
    access(0, 2'b00, 1, 32'h1000, 0, 0, 32'hFFFF_FF80, 2, "lb_1000");
    access(0, 2'b00, 0, 32'h1003, 0, 0, 32'h0000_0001, 2, "lbu_1003");
    access(0, 2'b01, 1, 32'h1002, 0, 0, 32'h0000_7F01, 2, "lh_1002");
    access(0, 2'b01, 1, 32'h1000, 0, 0, 32'hFFFF_8081, 2, "lh_1000");
    access(0, 2'b01, 0, 32'h1000, 0, 0, 32'h0000_8081, 2, "lhu_1000");
    access(0, 2'b00, 1, 32'h1001, 0, 0, 32'hFFFF_FF81, 2, "lb_1001");
    access(0, 2'b10, 0, 32'h1000, 0, 0, 32'h8081_7F01, 2, "lw_1000");
    lat = 2;
    access(0, 2'b00, 0, 32'h1002, 0, 0, 32'h0000_007F, 4, "lbu_1002_slow");
    lat = 0;
  endtask

  task automatic test_stores;
    int n;
    ack_en = 0;
    access(1, 2'b00, 0, 32'h2001, 32'h1234_56AA, {30'h800, 32'hAAAA_AAAA, 4'b0100}, 0, 0, "sb_2001");
    access(1, 2'b01, 0, 32'h2006, 32'h7777_BEEF, {30'h801, 32'hBEEF_BEEF, 4'b0011}, 0, 0, "sh_2006");
    access(1, 2'b10, 0, 32'h2008, 32'hDEAD_BEEF, {30'h802, 32'hDEAD_BEEF, 4'b1111}, 0, 0, "sw_2008");
    access(1, 2'b00, 0, 32'h200C, 32'h0000_0055, {30'h803, 32'h5555_5555, 4'b1000}, 0, 0, "sb_200c");
    @(negedge clk);
    total++;
    if ({ext_req, ext_we, ext_addr, ext_wdata, ext_be} !== {1'b1, 1'b1, 30'h800, 32'hAAAA_AAAA, 4'b0100}) begin
      bad++;
      $display("FAIL sb_lane got req=%b we=%b addr=%h wdata=%h be=%b want 1 1 00000800 aaaaaaaa 0100",
               ext_req, ext_we, ext_addr, ext_wdata, ext_be);
    end
    @(posedge clk);
    #1;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 ack_en = 1;
      end
    join_none
    access(1, 2'b01, 0, 32'h2010, 32'h0000_1234, {30'h804, 32'h1234_1234, 4'b1100}, 0, 6, "full_stall");
    n = 0;
    while ((dut.cnt != 0 || ext_req) && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (wq.size() != 0 || dut.cnt !== 0) begin
      bad++;
      $display("FAIL drain_all got pending=%0d count=%0d want 0 0", wq.size(), dut.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_after_store;
    mem[30'h1000] = 32'hCAFE_BABE;
    ack_en = 1; lat = 0;
    txlog.delete();
    access(1, 2'b10, 0, 32'h3000, 32'h1234_5678, {30'hC00, 32'h1234_5678, 4'hF}, 0, 0, "sw_3000");
    access(0, 2'b10, 0, 32'h4000, 0, 0, 32'hCAFE_BABE, 2, "lw_4000_overtake");
    access(0, 2'b10, 0, 32'h3000, 0, 0, 32'h1234_5678, 4, "lw_3000_hit");
    total++;
    if (txlog.size() != 3 || txlog[0] !== {1'b0, 30'h1000} || txlog[1] !== {1'b1, 30'hC00} ||
        txlog[2] !== {1'b0, 30'hC00}) begin
      bad++;
      $display("FAIL ext_order got n=%0d first=%h want 3 transactions rd 1000, wr c00, rd c00",
               txlog.size(), txlog.size() != 0 ? txlog[0] : 31'h0);
    end
  endtask

  task automatic test_misalign;
    logic [1:0]  szs [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] adr [3] = '{32'h1001, 32'h1002, 32'h1000};
    logic        wes [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      mem_en = 1; mem_we = wes[k]; mem_size = szs[k]; mem_addr = adr[k]; memdata_out = 32'hFFFF_FFFF;
      @(negedge clk);
      total++;
      if ({mem_misalign, mem_stall, ext_req} !== 3'b100) begin
        bad++;
        $display("FAIL misalign_%0d got misalign=%b stall=%b req=%b want 1 0 0", k, mem_misalign, mem_stall, ext_req);
      end
      @(posedge clk);
      #1 mem_en = 0;
      @(negedge clk);
      total++;
      if ({mem_misalign, ext_req, dut.cnt} !== 5'b0) begin
        bad++;
        $display("FAIL misalign_after_%0d got misalign=%b req=%b count=%0d want 0 0 0", k, mem_misalign, ext_req, dut.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_write;
    int n;
    ack_en = 0;
    access(1, 2'b10, 0, 32'h5000, 32'h0BAD_F00D, {30'h1400, 32'h0BAD_F00D, 4'hF}, 0, 0, "sw_5000");
    n = 0;
    while (!ext_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ext_req !== 1'b1 || ext_we !== 1'b1) begin
      bad++;
      $display("FAIL wr_wait_req got req=%b we=%b want 1 1", ext_req, ext_we);
    end
    #1 reset = 1;
    #1;
    total++;
    if ({memdata_in, mem_stall, mem_misalign, ext_req, ext_we, ext_addr, ext_wdata, ext_be, dut.cnt} !== 104'h0) begin
      bad++;
      $display("FAIL reset_mid_write got req=%b we=%b addr=%h be=%b rd=%h count=%0d want all zero",
               ext_req, ext_we, ext_addr, ext_be, memdata_in, dut.cnt);
    end
    wq.delete();
    @(posedge clk);
    #1 reset = 0;
    ack_en = 1;
    access(0, 2'b10, 0, 32'h5000, 0, 0, 32'h0, 2, "lw_5000_discarded");
  endtask

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_load_after_store;
    test_misalign;
    test_reset_mid_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
